// File: rtl/npu_conv_pkg.sv
// Shared definitions for the 3x3 convolution front end.
//   - default image geometry and pixel width
//   - feeder FSM state encoding
//   - counter width helpers
package npu_conv_pkg;

    localparam int DEF_BIT_DEPTH  = 8;
    localparam int DEF_IMG_WIDTH  = 28;
    localparam int DEF_IMG_HEIGHT = 28;

    localparam int DEF_COL_W = $clog2(DEF_IMG_WIDTH);
    localparam int DEF_ROW_W = $clog2(DEF_IMG_HEIGHT);

    localparam int FRAME_CNT_W = 16;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_ram.sv
// One image line of pixel storage, addressed by column.
// Read is combinational from the current address and returns the value
// stored before any write in the same cycle (read-old-write-new).
// Contents are not reset.
//   clk    : clock
//   we     : write enable
//   addr   : column address
//   wdata  : pixel written at addr on the rising edge when we=1
//   rdata  : pixel currently stored at addr
module conv_line_ram
    import npu_conv_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_WIDTH,
    parameter int WIDTH  = DEF_BIT_DEPTH,
    parameter int ADDR_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_line_feeder.sv
// Raster-order pixel front end for the 3x3 convolution window.
// Keeps the two previous rows in line buffers and, from row 2 of each
// frame onward, emits three vertically aligned pixels per accepted pixel.
//
// Optional feature: define CONV_FEEDER_FRAME_CNT_EN to add a 16-bit
// frame_cnt output counting completed frames.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   s_valid     : upstream pixel valid
//   s_ready     : upstream ready (mirrors dn_ready)
//   s_pixel     : upstream pixel
//   dn_ready    : window can take a write this cycle
//   wr_en       : window write strobe (registered)
//   out1..out3  : rows r-2, r-1, r at the accepted column (registered)
//   win_full    : the window holds a complete 3x3 after this write
//   frame_done  : pulse after the last pixel of a frame is accepted
//   frame_cnt   : completed frame count (optional)
//
// state  | meaning
// -------+-------------------------------------------------------
// FILL   | rows 0-1: loading line buffers, no window writes
// STREAM | rows 2..H-1: every accept produces one window write
module conv_line_feeder
    import npu_conv_pkg::*;
#(
    parameter int BIT_DEPTH  = DEF_BIT_DEPTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BIT_DEPTH-1:0] s_pixel,
    input  logic                 dn_ready,
    output logic                 wr_en,
    output logic [BIT_DEPTH-1:0] out1,
    output logic [BIT_DEPTH-1:0] out2,
    output logic [BIT_DEPTH-1:0] out3,
    output logic                 win_full,
    output logic                 frame_done
`ifdef CONV_FEEDER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    feeder_state_t state_q, state_d;

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 wr_en_q, wr_en_d;
    logic                 win_full_q, win_full_d;
    logic                 frame_done_q, frame_done_d;
    logic [BIT_DEPTH-1:0] out1_q, out1_d;
    logic [BIT_DEPTH-1:0] out2_q, out2_d;
    logic [BIT_DEPTH-1:0] out3_q, out3_d;

    logic                 accept;
    logic                 last_col;
    logic                 last_row;
    logic [BIT_DEPTH-1:0] lb0_rd;
    logic [BIT_DEPTH-1:0] lb1_rd;

    assign s_ready  = dn_ready;
    assign accept   = s_valid && dn_ready;
    assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));

    // lb0 holds row r-2, lb1 holds row r-1. Each accept shifts the column
    // up by one row: lb1's old entry moves into lb0, the new pixel into lb1.
    conv_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (BIT_DEPTH),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    conv_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (BIT_DEPTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (s_pixel),
        .rdata (lb1_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        wr_en_d      = 1'b0;
        win_full_d   = win_full_q;
        frame_done_d = 1'b0;
        out1_d       = out1_q;
        out2_d       = out2_q;
        out3_d       = out3_q;

        if (accept) begin
            out1_d = lb0_rd;
            out2_d = lb1_rd;
            out3_d = s_pixel;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                FILL: begin
                    win_full_d = 1'b0;
                    if ((row_q == ROW_W'(1)) && last_col) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    wr_en_d    = 1'b1;
                    win_full_d = (col_q >= COL_W'(2));
                    if (last_row && last_col) begin
                        state_d      = FILL;
                        frame_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            wr_en_q      <= 1'b0;
            win_full_q   <= 1'b0;
            frame_done_q <= 1'b0;
            out1_q       <= '0;
            out2_q       <= '0;
            out3_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wr_en_q      <= wr_en_d;
            win_full_q   <= win_full_d;
            frame_done_q <= frame_done_d;
            out1_q       <= out1_d;
            out2_q       <= out2_d;
            out3_q       <= out3_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign win_full   = win_full_q;
    assign frame_done = frame_done_q;
    assign out1       = out1_q;
    assign out2       = out2_q;
    assign out3       = out3_q;

`ifdef CONV_FEEDER_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Counts in step with frame_done so both are visible on the same cycle.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed bench for conv_line_feeder on a 4x4 image, pixel = base + row*16 + col.
module tb_conv_line_feeder;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pixel;
    logic       dn_ready;
    logic       wr_en;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       win_full;
    logic       frame_done;
`ifdef CONV_FEEDER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks;
    int errors;
    int exp_cnt;

    conv_line_feeder #(
        .BIT_DEPTH  (8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_pixel    (s_pixel),
        .dn_ready   (dn_ready),
        .wr_en      (wr_en),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .win_full   (win_full),
        .frame_done (frame_done)
`ifdef CONV_FEEDER_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},      16'(wr_en),      16'h0);
        check({tag, "_win_full"},   16'(win_full),   16'h0);
        check({tag, "_frame_done"}, 16'(frame_done), 16'h0);
        check({tag, "_out1"},       16'(out1),       16'h0);
        check({tag, "_out2"},       16'(out2),       16'h0);
        check({tag, "_out3"},       16'(out3),       16'h0);
`ifdef CONV_FEEDER_FRAME_CNT_EN
        check({tag, "_frame_cnt"},  frame_cnt,       16'h0);
`endif
    endtask

    // Streams one 4x4 frame. stall_idx: pixel index before which dn_ready
    // drops for 5 cycles. abort_idx: stop after accepting this pixel index.
    task automatic run_frame(input logic [7:0] base, input int stall_idx, input int abort_idx);
        int         n_wr;
        int         n_full;
        logic [7:0] pix;
        logic       last;
        n_wr   = 0;
        n_full = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                pix = base + 8'(r * 16 + c);
                if (r * 4 + c == stall_idx) begin
                    for (int k = 0; k < 5; k++) begin
                        dn_ready = 1'b0;
                        s_valid  = 1'b1;
                        s_pixel  = pix;
                        @(posedge clk);
                        #1;
                        check("stall_s_ready", 16'(s_ready), 16'h0);
                        check("stall_wr_en",   16'(wr_en),   16'h0);
                        check("stall_out3",    16'(out3),    16'(pix - 8'd1));
                    end
                end
                dn_ready = 1'b1;
                s_valid  = 1'b1;
                s_pixel  = pix;
                @(posedge clk);
                #1;
                last = (r == 3) && (c == 3);
                check("s_ready",    16'(s_ready),    16'h1);
                check("wr_en",      16'(wr_en),      16'(r >= 2));
                check("frame_done", 16'(frame_done), 16'(last));
                if (wr_en === 1'b1) n_wr++;
                if (wr_en === 1'b1 && win_full === 1'b1) n_full++;
                if (r >= 2) begin
                    check("out1",     16'(out1),     16'(base + 8'((r - 2) * 16 + c)));
                    check("out2",     16'(out2),     16'(base + 8'((r - 1) * 16 + c)));
                    check("out3",     16'(out3),     16'(pix));
                    check("win_full", 16'(win_full), 16'(c >= 2));
                end
                if (last) begin
                    exp_cnt++;
`ifdef CONV_FEEDER_FRAME_CNT_EN
                    check("frame_cnt", frame_cnt, 16'(exp_cnt));
`endif
                end
                if (r * 4 + c == abort_idx) return;
            end
        end
        check("wr_count",   16'(n_wr),   16'd8);
        check("full_count", 16'(n_full), 16'd4);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_cnt  = 0;
        rst_n    = 1'b1;
        s_valid  = 1'b0;
        s_pixel  = 8'h00;
        dn_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        check("reset_s_ready", 16'(s_ready), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1 and back-to-back frame 2 (offset 0x80).
        run_frame(8'h00, -1, -1);
        run_frame(8'h80, -1, -1);

        // Idle cycle: strobes drop, data held.
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_wr_en",      16'(wr_en),      16'h0);
        check("idle_frame_done", 16'(frame_done), 16'h0);
        check("idle_out1",       16'(out1),       16'h93);
        check("idle_out3",       16'(out3),       16'hB3);

        // Frame 3 with backpressure before accepting (3,2).
        run_frame(8'h00, 14, -1);

        // Frame aborted by reset after accepting (2,1).
        run_frame(8'h00, -1, 9);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh frame after reset.
        run_frame(8'h40, -1, -1);

        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("end_wr_en", 16'(wr_en), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_line_feeder.md
# conv_line_feeder

Raster-order pixel front end for the 3x3 convolution window in the NPU datapath. It accepts one pixel per handshake, keeps the two previous image rows in internal line buffers, and drives three vertically aligned pixels per column plus a write strobe into the 3-row window shift register. Rows 0 and 1 of each frame only fill the buffers. From row 2 onward, every accepted pixel produces one window write.

## Interface
- `BIT_DEPTH`, 8, pixel width; matches the window's data width
- `IMG_WIDTH`, 28, pixels per row (≥3)
- `IMG_HEIGHT`, 28, rows per frame (≥3)
- `clk`  input  1  rising-edge clock; the block uses one clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `s_valid`  input  1  upstream pixel valid
- `s_ready`  output  1  upstream ready; equals `dn_ready`, combinational
- `s_pixel`  input  BIT_DEPTH  upstream pixel, raster order
- `dn_ready`  input  1  downstream may accept a window write this cycle
- `wr_en`  output  1  window write strobe, registered
- `out1`  output  BIT_DEPTH  pixel from row r-2, same column, registered
- `out2`  output  BIT_DEPTH  pixel from row r-1, same column, registered
- `out3`  output  BIT_DEPTH  pixel from row r (current), registered
- `win_full`  output  1  qualifies `wr_en`; after this write the window holds a complete 3x3 (col ≥ 2)
- `frame_done`  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept occurs when `s_valid && s_ready`. No state changes on cycles without an accept, except that `wr_en` and `frame_done` return to 0.
- Counters:
  - `col` runs 0..IMG_WIDTH-1 and wraps to 0, incrementing `row`.
  - `row` runs 0..IMG_HEIGHT-1 and wraps to 0 at end of frame.
- Line buffers `lb0` and `lb1` each hold IMG_WIDTH entries, addressed by `col`. On every accept:
  - `out1 <= lb0[col]` and `out2 <= lb1[col]` (old values).
  - `out3 <= s_pixel`.
  - `lb0[col] <= lb1[col]` and `lb1[col] <= s_pixel`.
- States:
  - **FILL**: `row` < 2; `wr_en` is held 0. Transition to STREAM when the accept at `row`=1, `col`=IMG_WIDTH-1 occurs.
  - **STREAM**: every accept sets `wr_en`=1 in the next cycle, with `win_full`=(`col`≥2). Transition to FILL on the accept at `row`=IMG_HEIGHT-1, `col`=IMG_WIDTH-1; that same accept sets `frame_done`=1 in the next cycle.
- Back-to-back frames need no idle cycles between them.
- The line buffers never require clearing; FILL overwrites them before any use.
- Reset values: `wr_en`, `win_full`, `frame_done`, `out1`, `out2`, `out3` are all 0; `row`=`col`=0; state is FILL. Line buffer contents are undefined and not reset.
- Reset asserted mid-frame aborts the frame. The next accepted pixel is treated as row 0, col 0.

## Timing
- Latency is 1 cycle from accept to `wr_en`/`outN`.
- Outputs are held between strobes. `wr_en` is high for exactly one cycle per STREAM accept.
- Sustained throughput is 1 pixel per cycle while `s_valid` and `dn_ready` are both high.
- `dn_ready` low forces `s_ready` low and freezes all counters and buffers.
- In STREAM, window writes per frame = (IMG_HEIGHT-2)·IMG_WIDTH; writes with `win_full` = (IMG_HEIGHT-2)·(IMG_WIDTH-2).

## Configuration
- `CONV_FEEDER_FRAME_CNT_EN` defined:
  - Adds output port `frame_cnt` (16 bits, reset 0).
  - `frame_cnt` increments in the same cycle `frame_done` rises and wraps at 0xFFFF→0.
- `CONV_FEEDER_FRAME_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `npu_conv_pkg`:
  - Default `BIT_DEPTH`, `IMG_WIDTH`, `IMG_HEIGHT`.
  - State enum `feeder_state_t` {FILL, STREAM}.
  - Counter width constants computed via `$clog2`.
- One sub-module `conv_line_ram`: single IMG_WIDTH x BIT_DEPTH array with read-old-write-new behaviour at one address. It is instantiated twice, for `lb0` and `lb1`.

## Test plan
- **Basic fill/stream.** Setup: IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row·16+col, streamed continuously.
  - No `wr_en` during rows 0–1.
  - Accept of (2,0) → next cycle `wr_en`=1, `out1`=0x00, `out2`=0x10, `out3`=0x20, `win_full`=0.
  - Accept of (2,2) → `win_full`=1.
- **Frame counts.** Same 4x4 frame → exactly 8 `wr_en` pulses and 4 with `win_full`. `frame_done` pulses once, 1 cycle after (3,3) is accepted.
- **Backpressure.** Drop `dn_ready` for 5 cycles mid-row 3 → `s_ready`=0 and no `wr_en`. After release, the next output resumes with the correct column values (e.g. `out3`=0x32 after accepting (3,2)).
- **Mid-frame reset.** Assert `rst_n`=0 at row 2, col 1 → all outputs 0 immediately. The following frame produces its first `wr_en` only at its row 2, col 0, with correct data.
- **Back-to-back frames.** Two frames with values offset by 0x80 → the second frame's rows 0–1 produce no `wr_en`. The first second-frame write carries `out1`=0x80, `out2`=0x90, `out3`=0xA0.
- **Frame counter.** With `CONV_FEEDER_FRAME_CNT_EN` defined, run 3 frames → `frame_cnt` reads 1, 2, 3 after each `frame_done`.
